// File: rtl/key_sweep_pkg.sv
// Shared definitions for the key_sweep block: state encoding of the sweep controller.
package key_sweep_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/key_sweep_if.sv
// Control and key/match handshake bundle between key_sweep and its user / comparator.
interface key_sweep_if #(
  parameter int WIDTH    = 8,
  parameter int MAX_KEYS = 256
);
  localparam int IW = $clog2(MAX_KEYS);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic             match;
  logic             busy;
  logic             done;
  logic             found;
  logic [IW-1:0]    idx;

  modport master (
    input  start, abort, key_ready, match,
    output key, key_valid, busy, done, found, idx
  );

  modport slave (
    output start, abort, key_ready, match,
    input  key, key_valid, busy, done, found, idx
  );

endinterface

// File: rtl/key_sweep.sv
// Sweeps an arithmetic key sequence into an external comparator and reports the
// index of the first match, or not-found once MAX_KEYS keys have been rejected.
module key_sweep
  import key_sweep_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] KEY_BASE = '0,
  parameter logic [WIDTH-1:0] KEY_STEP = WIDTH'(1),
  parameter int               MAX_KEYS = 256
) (
  input  logic       clk,
  input  logic       rst,
  key_sweep_if.master bus
);

  localparam int            IW   = $clog2(MAX_KEYS);
  localparam logic [IW-1:0] LAST = IW'(MAX_KEYS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] key_r;
  logic [IW-1:0]    cnt;
  logic             found_r;
  logic [IW-1:0]    idx_r;

  logic             handshake;
  logic             load;
  logic             advance;
  logic             finish_hit;
  logic             finish_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // abort wins over a same-cycle handshake, so the key is never consumed on abort
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    advance     = 1'b0;
    finish_hit  = 1'b0;
    finish_miss = 1'b0;
    handshake   = (state == SWEEP) && bus.key_ready;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SWEEP;
          load       = 1'b1;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (handshake) begin
          if (bus.match) begin
            finish_hit = 1'b1;
            state_next = DONE;
          end else if (cnt == LAST) begin
            finish_miss = 1'b1;
            state_next  = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r <= '0;
      cnt   <= '0;
    end else if (load) begin
      key_r <= KEY_BASE;
      cnt   <= '0;
    end else if (advance) begin
      key_r <= key_r + KEY_STEP;
      cnt   <= cnt + IW'(1);
    end
  end

  // Result registers survive start and abort; only a completed sweep updates them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_r <= 1'b0;
      idx_r   <= '0;
    end else if (finish_hit) begin
      found_r <= 1'b1;
      idx_r   <= cnt;
    end else if (finish_miss) begin
      found_r <= 1'b0;
      idx_r   <= LAST;
    end
  end

  assign bus.key       = key_r;
  assign bus.key_valid = (state == SWEEP);
  assign bus.busy      = (state == SWEEP);
  assign bus.done      = (state == DONE);
  assign bus.found     = found_r;
  assign bus.idx       = idx_r;

endmodule

// File: tb/tb_key_sweep.sv
// Randomized bench for key_sweep: an arithmetic reference model fills a scoreboard that a
// monitor drains on every key handshake and every done pulse, across three parameter sets.
module tb_key_sweep;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } result_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       start_req;
  logic       abort_req;
  logic       ready;
  logic [7:0] lock;

  int base_of[3] = '{0, 0, 250};
  int step_of[3] = '{1, 1, 3};
  int max_of[3]  = '{256, 100, 100};
  logic last_found[3];
  int   last_idx[3];

  logic [7:0] key_q[$];
  result_t    res_q[$];

  int n_cmp      = 0;
  int n_bad      = 0;
  int hs_count   = 0;
  int done_count = 0;

  logic [7:0] mon_key;
  logic       mon_valid;
  logic       mon_busy;
  logic       mon_done;
  logic       mon_found;
  logic [7:0] mon_idx;

  always #5 clk = ~clk;

  key_sweep_if #(.WIDTH(8), .MAX_KEYS(256)) bus_a ();
  key_sweep_if #(.WIDTH(8), .MAX_KEYS(100)) bus_b ();
  key_sweep_if #(.WIDTH(8), .MAX_KEYS(100)) bus_c ();

  // Each instance gets its own lock/key comparator fed from the shared lock value
  assign bus_a.start     = start_req && (sel == 2'd0);
  assign bus_a.abort     = abort_req && (sel == 2'd0);
  assign bus_a.key_ready = ready;
  assign bus_a.match     = bus_a.key_valid && (bus_a.key == lock);

  assign bus_b.start     = start_req && (sel == 2'd1);
  assign bus_b.abort     = abort_req && (sel == 2'd1);
  assign bus_b.key_ready = ready;
  assign bus_b.match     = bus_b.key_valid && (bus_b.key == lock);

  assign bus_c.start     = start_req && (sel == 2'd2);
  assign bus_c.abort     = abort_req && (sel == 2'd2);
  assign bus_c.key_ready = ready;
  assign bus_c.match     = bus_c.key_valid && (bus_c.key == lock);

  key_sweep u_a (.clk(clk), .rst(rst), .bus(bus_a));
  key_sweep #(.MAX_KEYS(100)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  key_sweep #(.KEY_BASE(8'd250), .KEY_STEP(8'd3), .MAX_KEYS(100)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  always_comb begin
    mon_key   = bus_a.key;
    mon_valid = bus_a.key_valid;
    mon_busy  = bus_a.busy;
    mon_done  = bus_a.done;
    mon_found = bus_a.found;
    mon_idx   = bus_a.idx;
    case (sel)
      2'd1: begin
        mon_key   = bus_b.key;
        mon_valid = bus_b.key_valid;
        mon_busy  = bus_b.busy;
        mon_done  = bus_b.done;
        mon_found = bus_b.found;
        mon_idx   = {1'b0, bus_b.idx};
      end
      2'd2: begin
        mon_key   = bus_c.key;
        mon_valid = bus_c.key_valid;
        mon_busy  = bus_c.busy;
        mon_done  = bus_c.done;
        mon_found = bus_c.found;
        mon_idx   = {1'b0, bus_c.idx};
      end
      default: begin
      end
    endcase
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: %s", name, what);
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc - 1) % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Key i of a sweep is base + i*step mod 256; the sweep stops at the first key equal to the lock
  task automatic model_sweep(input int inst, input logic [7:0] lk, output logic f, output int ix);
    logic [7:0] k;
    f  = 1'b0;
    ix = max_of[inst] - 1;
    for (int i = 0; i < max_of[inst]; i++) begin
      k = 8'((base_of[inst] + i * step_of[inst]) % 256);
      key_q.push_back(k);
      if (k == lk) begin
        f  = 1'b1;
        ix = i;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mon_valid && ready && !abort_req) begin
        hs_count++;
        if (key_q.size() == 0) fail_now("handshake", "actual extra handshake, required none");
        else check("key", mon_key, key_q.pop_front());
      end
      if (mon_done) begin
        result_t r;
        done_count++;
        if (res_q.size() == 0) begin
          fail_now("done", "actual unexpected done pulse, required none");
        end else begin
          r = res_q.pop_front();
          check("sb_found", mon_found, r.found);
          check("sb_idx", mon_idx, r.idx);
        end
      end
    end
  end

  task automatic applyStimulus(input int inst, input logic [7:0] lk, input int mode);
    logic    f;
    int      ix;
    int      nhs;
    int      cyc;
    bit      seen;
    result_t r;
    sel  = inst[1:0];
    lock = lk;
    model_sweep(inst, lk, f, ix);
    nhs     = key_q.size();
    r.found = f;
    r.idx   = 8'(ix);
    res_q.push_back(r);
    @(posedge clk); #1;
    start_req = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4 * max_of[inst] + 20) begin
      @(posedge clk); #1;
      cyc++;
      start_req = (cyc == 3) && mon_busy;
      ready     = ready_for(mode, cyc);
      if (mon_done) seen = 1'b1;
    end
    start_req = 1'b0;
    ready     = 1'b0;
    if (!seen) begin
      fail_now("timeout", "actual no done pulse, required done");
      abort_req = 1'b1;
      @(posedge clk); #1;
      abort_req = 1'b0;
      key_q.delete();
      res_q.delete();
    end else begin
      if (mode == 0) check("latency", cyc, nhs + 1);
      @(negedge clk); #1;
      checkOutput(inst, f, ix);
    end
  endtask

  task automatic checkOutput(input int inst, input logic f, input int ix);
    check("keys_left", key_q.size(), 0);
    check("results_left", res_q.size(), 0);
    check("found", mon_found, f);
    check("idx", mon_idx, ix);
    @(posedge clk); #1;
    check("done_width", mon_done, 0);
    last_found[inst] = f;
    last_idx[inst]   = ix;
  endtask

  task automatic run_abort(input int inst, input logic [7:0] lk, input int after);
    logic f;
    int   ix;
    int   h0;
    int   d0;
    int   cyc;
    sel  = inst[1:0];
    lock = lk;
    model_sweep(inst, lk, f, ix);
    $display("[TB] abort sweep: lock would hit=%0b at index %0d", f, ix);
    h0 = hs_count;
    d0 = done_count;
    @(posedge clk); #1;
    start_req = 1'b1;
    ready     = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start_req = 1'b0;
    end while ((hs_count - h0) < after && cyc < 50);
    if (cyc >= 50) fail_now("abort_wait", "actual too few handshakes, required more");
    abort_req = 1'b1;
    @(posedge clk); #1;
    abort_req = 1'b0;
    ready     = 1'b0;
    check("abort_busy", mon_busy, 0);
    check("abort_valid", mon_valid, 0);
    check("abort_found", mon_found, last_found[inst]);
    check("abort_idx", mon_idx, last_idx[inst]);
    check("abort_handshakes", hs_count - h0, after);
    key_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_count - d0, 0);
  endtask

  task automatic run_reset_mid_sweep();
    logic f;
    int   ix;
    sel  = 2'd0;
    lock = 8'd200;
    model_sweep(0, 8'd200, f, ix);
    $display("[TB] reset sweep: interrupted before hit=%0b at index %0d", f, ix);
    @(posedge clk); #1;
    start_req = 1'b1;
    ready     = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_key", mon_key, 0);
    check("rst_valid", mon_valid, 0);
    check("rst_busy", mon_busy, 0);
    check("rst_done", mon_done, 0);
    check("rst_found", mon_found, 0);
    check("rst_idx", mon_idx, 0);
    key_q.delete();
    res_q.delete();
    for (int i = 0; i < 3; i++) begin
      last_found[i] = 1'b0;
      last_idx[i]   = 0;
    end
    ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    sel       = 2'd0;
    start_req = 1'b0;
    abort_req = 1'b0;
    ready     = 1'b0;
    lock      = 8'd0;
    for (int i = 0; i < 3; i++) begin
      last_found[i] = 1'b0;
      last_idx[i]   = 0;
    end
    #2;
    check("reset_key", mon_key, 0);
    check("reset_valid", mon_valid, 0);
    check("reset_busy", mon_busy, 0);
    check("reset_done", mon_done, 0);
    check("reset_found", mon_found, 0);
    check("reset_idx", mon_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 8'd5, 0);
    applyStimulus(1, 8'd200, 0);
    applyStimulus(0, 8'd3, 1);
    applyStimulus(2, 8'd3, 0);
    run_abort(0, 8'd2, 2);
    run_reset_mid_sweep();
    applyStimulus(0, 8'd9, 0);

    for (int n = 0; n < 12; n++) begin
      int         inst;
      logic [7:0] lk;
      int         mode;
      inst = $urandom_range(0, 2);
      lk   = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      applyStimulus(inst, lk, mode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
